// File: rtl/vgahdmi_fetch_scheduler.sv
// Pixel-data fetch sequencer: strobe/ack memory reads into a small FIFO, head presented as bytes.
// Optional FETCH_STATS_EN adds a saturating underrun_count output.
module vgahdmi_fetch_scheduler #(
  parameter int C_addr_bits       = 30,
  parameter int C_fifo_depth      = 16,
  parameter int C_words_per_frame = 38400
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic [C_addr_bits-1:0] base_addr,
  input  logic                   vga_vsync,
  input  logic                   fetch_next,
  output logic [7:0]             red_byte,
  output logic [7:0]             green_byte,
  output logic [7:0]             blue_byte,
  output logic [7:0]             bright_byte,
  output logic [C_addr_bits-1:0] mem_addr,
  output logic                   mem_strobe,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_data,
  output logic                   underrun,
`ifdef FETCH_STATS_EN
  output logic [15:0]            underrun_count,
`endif
  output logic                   frame_done
);

  localparam int PW   = $clog2(C_fifo_depth);
  localparam int CW   = PW + 1;
  localparam int WL_W = $clog2(C_words_per_frame + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_REQ} state_t;

  state_t                 state_q, state_d;
  logic                   vsync_q;
  logic [C_addr_bits-1:0] addr_q, addr_d;
  logic [WL_W-1:0]        wl_q, wl_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [31:0]            head_q, head_d;
  logic                   strobe_q, strobe_d;
  logic                   und_q, und_d;
  logic                   done_q, done_d;
  logic                   frame_start, push_en, pop_en, und_evt;
  logic [31:0]            fifo_mem [C_fifo_depth];

  always_comb begin
    frame_start = vsync_q & ~vga_vsync;
    state_d  = state_q;
    addr_d   = addr_q;
    wl_d     = wl_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    und_d    = und_q;
    done_d   = 1'b0;
    push_en  = 1'b0;
    pop_en   = 1'b0;
    und_evt  = 1'b0;
    if (frame_start) begin
      // Flush and restart; a same-cycle ack or pop is discarded.
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      addr_d  = base_addr;
      wl_d    = WL_W'(C_words_per_frame);
      und_d   = 1'b0;
      state_d = S_FILL;
    end else begin
      push_en = (state_q == S_REQ) && mem_ack;
      pop_en  = fetch_next && (cnt_q != '0);
      und_evt = fetch_next && (cnt_q == '0);
      if (und_evt) und_d = 1'b1;
      if (pop_en)  rd_d = rd_q + PW'(1);
      if (push_en) wr_d = wr_q + PW'(1);
      cnt_d = cnt_q + CW'(push_en) - CW'(pop_en);
      case (state_q)
        S_FILL: begin
          if (wl_q == '0)                                  state_d = S_IDLE;
          else if (cnt_q < CW'(C_fifo_depth) || pop_en)     state_d = S_REQ;
        end
        S_REQ: begin
          if (mem_ack) begin
            addr_d  = addr_q + C_addr_bits'(1);
            wl_d    = wl_q - WL_W'(1);
            done_d  = (wl_q == WL_W'(1));
            state_d = S_FILL;
          end
        end
        default: ;
      endcase
    end
    strobe_d = (state_d == S_REQ);
    // Head bypasses the array when the word being pushed becomes the head.
    if (cnt_d == '0)                  head_d = '0;
    else if (push_en && rd_d == wr_q) head_d = mem_data;
    else                              head_d = fifo_mem[rd_d];
  end

  always_ff @(posedge clk_pixel) begin
    if (push_en) fifo_mem[wr_q] <= mem_data;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q  <= S_IDLE;
      vsync_q  <= 1'b1;
      addr_q   <= '0;
      wl_q     <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      head_q   <= '0;
      strobe_q <= 1'b0;
      und_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= vga_vsync;
      addr_q   <= addr_d;
      wl_q     <= wl_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      head_q   <= head_d;
      strobe_q <= strobe_d;
      und_q    <= und_d;
      done_q   <= done_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;
  always_comb begin
    ucnt_d = ucnt_q;
    if (und_evt && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end
  always_ff @(posedge clk_pixel) begin
    if (reset) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end
  assign underrun_count = ucnt_q;
`endif

  assign red_byte    = head_q[7:0];
  assign green_byte  = head_q[15:8];
  assign blue_byte   = head_q[23:16];
  assign bright_byte = head_q[31:24];
  assign mem_addr    = addr_q;
  assign mem_strobe  = strobe_q;
  assign underrun    = und_q;
  assign frame_done  = done_q;

endmodule
